// File: rtl/axis_processor.sv
// AXI-Stream command front end for the neuromorphic network core, with the
// stub `network` it drives (one spike per input whose charge is non-zero).

module network #(
  parameter int NUM_INP      = 2,
  parameter int CHARGE_WIDTH = 2,
  parameter int OUT_WIDTH    = 2
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic                            en,
  input  logic                            clr,
  input  logic [NUM_INP*CHARGE_WIDTH-1:0] inp,
  output logic [OUT_WIDTH-1:0]            out
);

  logic [OUT_WIDTH-1:0] spike;

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_spike
    if (i < NUM_INP) begin : g_in
      assign spike[i] = |inp[i*CHARGE_WIDTH +: CHARGE_WIDTH];
    end else begin : g_none
      assign spike[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)   out <= '0;
    else if (clr) out <= '0;
    else if (en)  out <= spike;
  end

endmodule

// state    | meaning
// S_INIT   | first cycle out of reset, not yet accepting commands
// S_IDLE   | accepting commands
// S_STEP_A | network enabled with current charges; one-shots consumed, generators advanced
// S_STEP_B | network output captured into the output packet
// S_HOLD   | output packet waiting for m_axis_tready
module axis_processor #(
  parameter int INP_WIDTH    = 16,
  parameter int OUT_WIDTH    = 2,
  parameter int NUM_INP      = 2,
  parameter int CHARGE_WIDTH = 2,
  parameter int PERIOD_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [INP_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam int IDX_W = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_STEP_A = 3'd2;
  localparam logic [2:0] S_STEP_B = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [2:0] OP_RUN = 3'b001;
  localparam logic [2:0] OP_SPK = 3'b010;
  localparam logic [2:0] OP_CLR = 3'b011;
  localparam logic [2:0] OP_PER = 3'b100;

  logic [2:0]                    state;
  logic [12:0]                   remaining;
  logic [CHARGE_WIDTH-1:0]       pend       [NUM_INP];
  logic [CHARGE_WIDTH-1:0]       per_val    [NUM_INP];
  logic [PERIOD_WIDTH-1:0]       per_period [NUM_INP];
  logic [PERIOD_WIDTH-1:0]       per_cnt    [NUM_INP];
  logic [NUM_INP-1:0]            fire;
  logic [NUM_INP*CHARGE_WIDTH-1:0] charge;
  logic [OUT_WIDTH-1:0]          net_out;

  logic                          accept;
  logic [2:0]                    opcode;
  logic [IDX_W-1:0]              cmd_idx;
  logic [CHARGE_WIDTH-1:0]       cmd_val;
  logic [PERIOD_WIDTH-1:0]       cmd_period;
  logic [12:0]                   run_len;
  logic                          net_en;
  logic                          net_clr;
  logic                          unused_tdata;

  assign s_axis_tready = (state == S_IDLE);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign opcode        = s_axis_tdata[15:13];
  assign cmd_idx       = s_axis_tdata[12 -: IDX_W];
  assign cmd_val       = s_axis_tdata[11 -: CHARGE_WIDTH];
  assign cmd_period    = s_axis_tdata[9 -: PERIOD_WIDTH];
  assign run_len       = s_axis_tdata[12:0];
  assign unused_tdata  = ^s_axis_tdata;

  assign net_en  = (state == S_STEP_A);
  assign net_clr = accept && (opcode == OP_CLR);

  // One-shot and periodic charge on the same input add, clipped at full scale.
  always_comb begin
    logic [CHARGE_WIDTH:0] sum;
    sum    = '0;
    fire   = '0;
    charge = '0;
    for (int i = 0; i < NUM_INP; i++) begin
      fire[i] = (per_period[i] != '0) && (per_cnt[i] == per_period[i] - PERIOD_WIDTH'(1));
      sum = {1'b0, pend[i]} + {1'b0, (fire[i] ? per_val[i] : {CHARGE_WIDTH{1'b0}})};
      charge[i*CHARGE_WIDTH +: CHARGE_WIDTH] = sum[CHARGE_WIDTH] ? {CHARGE_WIDTH{1'b1}}
                                                                 : sum[CHARGE_WIDTH-1:0];
    end
  end

  network #(
    .NUM_INP      (NUM_INP),
    .CHARGE_WIDTH (CHARGE_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_network (
    .clk   (clk),
    .arstn (arstn),
    .en    (net_en),
    .clr   (net_clr),
    .inp   (charge),
    .out   (net_out)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= S_INIT;
      remaining     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      for (int i = 0; i < NUM_INP; i++) begin
        pend[i]       <= '0;
        per_val[i]    <= '0;
        per_period[i] <= '0;
        per_cnt[i]    <= '0;
      end
    end else begin
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_RUN: begin
                if (run_len != '0) begin
                  remaining <= run_len;
                  state     <= S_STEP_A;
                end
              end
              OP_SPK: begin
                for (int i = 0; i < NUM_INP; i++)
                  if (cmd_idx == IDX_W'(i)) pend[i] <= cmd_val;
              end
              OP_CLR: begin
                for (int i = 0; i < NUM_INP; i++) begin
                  pend[i]       <= '0;
                  per_val[i]    <= '0;
                  per_period[i] <= '0;
                  per_cnt[i]    <= '0;
                end
              end
              OP_PER: begin
                for (int i = 0; i < NUM_INP; i++) begin
                  if (cmd_idx == IDX_W'(i)) begin
                    per_val[i]    <= cmd_val;
                    per_period[i] <= cmd_period;
                    per_cnt[i]    <= '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        S_STEP_A: begin
          for (int i = 0; i < NUM_INP; i++) begin
            pend[i] <= '0;
            if (per_period[i] != '0)
              per_cnt[i] <= fire[i] ? '0 : per_cnt[i] + PERIOD_WIDTH'(1);
          end
          state <= S_STEP_B;
        end
        S_STEP_B: begin
          m_axis_tdata  <= net_out;
          m_axis_tvalid <= 1'b1;
          state         <= S_HOLD;
        end
        S_HOLD: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            remaining     <= remaining - 13'd1;
            state         <= (remaining == 13'd1) ? S_IDLE : S_STEP_A;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_processor.sv
// Randomised self-checking bench for axis_processor against a timestep-level
// reference model of charges and periodic generators.

module tb_axis_processor;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [1:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state: pending one-shots, generator settings, steps since load
  int m_pend   [2];
  int m_val    [2];
  int m_period [2];
  int m_steps  [2];
  logic [1:0] got_q[$];

  always #5 clk = ~clk;

  axis_processor dut (
    .clk           (clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_val[i] = 0; m_period[i] = 0; m_steps[i] = 0;
    end
  endtask

  task automatic model_cmd(input logic [15:0] c);
    int idx;
    idx = int'(c[12]);
    case (c[15:13])
      3'b010: m_pend[idx] = int'(c[11:10]);
      3'b011: model_clear();
      3'b100: begin
        m_val[idx]    = int'(c[11:10]);
        m_period[idx] = int'(c[9:5]);
        m_steps[idx]  = 0;
      end
      default: ;
    endcase
  endtask

  // A generator fires on every period-th step after it was loaded.
  task automatic model_step(output logic [1:0] e);
    int total;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      total = m_pend[i];
      if (m_period[i] != 0 && ((m_steps[i] + 1) % m_period[i]) == 0) total += m_val[i];
      if (total > 3) total = 3;
      e[i] = (total != 0);
      m_steps[i]++;
      m_pend[i] = 0;
    end
  endtask

  task automatic send_cmd(input logic [15:0] c, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    s_tdata  = c;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_tready) begin
      errors++;
      $display("FAIL accept_timeout cmd=%h s_axis_tready=%b required 1", c, s_tready);
      s_tvalid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      model_cmd(c);
      #1 s_tvalid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic do_run(input int n, input int bp_min, input int bp_max);
    bit ok;
    int cnt, hold;
    logic [1:0] exp;
    send_cmd({3'b001, 13'(n)}, ok);
    if (!ok) return;
    if (n == 0) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
          errors++;
          $display("FAIL run0_noop tvalid=%b tready=%b required 0/1", m_tvalid, s_tready);
        end
      end
      return;
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL latency_c1 tvalid=%b s_tready=%b required 0/0", m_tvalid, s_tready);
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_c2 tvalid=%b required 0", m_tvalid);
    end
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency_c3 tvalid=%b required 1", m_tvalid);
    end
    for (int p = 0; p < n; p++) begin
      cnt = 0;
      while (!m_tvalid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (!m_tvalid) begin
        errors++;
        $display("FAIL packet_timeout packet=%0d of %0d tvalid=%b required 1", p, n, m_tvalid);
        return;
      end
      model_step(exp);
      checks++;
      if (m_tdata !== exp) begin
        errors++;
        $display("FAIL packet_data packet=%0d got=%b required=%b", p, m_tdata, exp);
      end
      hold = $urandom_range(bp_min, bp_max);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== exp || s_tready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_hold packet=%0d tvalid=%b tdata=%b s_tready=%b required 1/%b/0",
                   p, m_tvalid, m_tdata, s_tready, exp);
        end
      end
      got_q.push_back(m_tdata);
      m_tready = 1'b1;
      @(negedge clk);
      m_tready = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
        errors++;
        $display("FAIL run_end tvalid=%b s_tready=%b required 0/1", m_tvalid, s_tready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    #180;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== 2'b00) begin
      errors++;
      $display("FAIL reset_state tvalid=%b s_tready=%b tdata=%b required 0/0/00", m_tvalid, s_tready, m_tdata);
    end
    @(negedge clk);
    arstn = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release s_tready=%b required 1", s_tready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_packet tvalid=%b required 0", m_tvalid);
      end
    end
  endtask

  task automatic test_spike();
    bit ok;
    got_q.delete();
    send_cmd(16'h6000, ok);
    send_cmd(16'h4400, ok);
    do_run(1, 0, 0);
    do_run(1, 0, 2);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 2'b01 || got_q[1] !== 2'b00) begin
      errors++;
      $display("FAIL spike_oneshot count=%0d first=%b second=%b required 2/01/00",
               got_q.size(), got_q[0], got_q[1]);
    end
  endtask

  task automatic test_periodic();
    bit ok;
    logic [1:0] req [6];
    req = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    got_q.delete();
    send_cmd(16'h6000, ok);
    send_cmd(16'h8460, ok);
    do_run(6, 0, 1);
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL periodic_count got=%0d required 6", got_q.size());
    end else begin
      for (int t = 0; t < 6; t++) begin
        checks++;
        if (got_q[t] !== req[t]) begin
          errors++;
          $display("FAIL periodic_t%0d got=%b required=%b", t, got_q[t], req[t]);
        end
      end
    end
  endtask

  task automatic test_two_generators();
    bit ok;
    logic [1:0] req [6];
    req = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
    got_q.delete();
    send_cmd(16'h6000, ok);
    send_cmd(16'h8460, ok);
    do_run(1, 0, 0);
    send_cmd(16'h9440, ok);
    do_run(49, 0, 1);
    checks++;
    if (got_q.size() != 50) begin
      errors++;
      $display("FAIL two_gen_count got=%0d required 50", got_q.size());
    end else begin
      for (int t = 0; t < 6; t++) begin
        checks++;
        if (got_q[t] !== req[t]) begin
          errors++;
          $display("FAIL two_gen_t%0d got=%b required=%b", t, got_q[t], req[t]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    got_q.delete();
    send_cmd(16'h6000, ok);
    send_cmd(16'h4C00, ok);
    send_cmd(16'h9440, ok);
    do_run(3, 3, 7);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL backpressure_count got=%0d required 3", got_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [2:0] op;
    logic [15:0] c;
    send_cmd(16'h6000, ok);
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'b001) begin
        do_run($urandom_range(0, 6), 0, 3);
      end else begin
        c = {op, 13'($urandom)};
        send_cmd(c, ok);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int cnt;
    send_cmd(16'h6000, ok);
    send_cmd(16'h8420, ok);
    send_cmd(16'h9820, ok);
    send_cmd(16'h2031, ok);
    cnt = 0;
    while (!m_tvalid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 2'b11) begin
      errors++;
      $display("FAIL midrun_first tvalid=%b tdata=%b required 1/11", m_tvalid, m_tdata);
    end
    #2 arstn = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset tvalid=%b s_tready=%b required 0/0", m_tvalid, s_tready);
    end
    #40;
    @(negedge clk);
    arstn = 1'b1;
    model_clear();
    got_q.delete();
    do_run(1, 0, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 2'b00) begin
      errors++;
      $display("FAIL midrun_after count=%0d tdata=%b required 1/00", got_q.size(), got_q[0]);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_spike();
    test_periodic();
    test_two_generators();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
